// File: rtl/branch_unit.sv
// branch_unit: evaluates the PSW branch condition from IR and, when taken,
// requests the bus and strobes a one-cycle PC load of the branch target.
module branch_unit #(
    parameter int DATA_W = 16,
    parameter int OFF_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        IR_cond,
    input  logic [OFF_W-1:0]  IR_offset,
    input  logic [1:0]        PSW_in,
    input  logic [DATA_W-1:0] PC_in,
    input  logic              bus_gnt,
    output logic              bus_req,
    output logic [DATA_W-1:0] PC_out,
    output logic              PC_load,
    output logic              taken,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, EVAL, CALC, REQ, LOAD, DONE} state_t;
    state_t state, state_nx;
    logic [2:0]        cond_q;
    logic [OFF_W-1:0]  off_q;
    logic [1:0]        psw_q;
    logic [DATA_W-1:0] pc_q;
    logic [7:0]        cond_tab;
    logic              z, n;
    assign z = psw_q[0];
    assign n = psw_q[1];
    // bit i of the table is the outcome of condition code i
    assign cond_tab = {1'b0, ~n & ~z, n | z, ~n, n, ~z, z, 1'b1};
    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_nx;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cond_q <= '0;
            off_q  <= '0;
            psw_q  <= '0;
            pc_q   <= '0;
            taken  <= 1'b0;
            PC_out <= '0;
        end else begin
            if (state == IDLE && start) begin
                cond_q <= IR_cond;
                off_q  <= IR_offset;
                psw_q  <= PSW_in;
                pc_q   <= PC_in;
            end
            if (state == EVAL) taken <= cond_tab[cond_q];
            if (state == CALC) PC_out <= pc_q + {{(DATA_W-OFF_W){off_q[OFF_W-1]}}, off_q};
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? EVAL : IDLE;
            EVAL:    state_nx = cond_tab[cond_q] ? CALC : DONE;
            CALC:    state_nx = REQ;
            REQ:     state_nx = bus_gnt ? LOAD : REQ;
            LOAD:    state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        bus_req = state == REQ;
        PC_load = state == LOAD;
        done    = state == DONE;
        busy    = state != IDLE;
    end
endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: scoreboard bench for branch_unit; expected taken/target are
// pushed when start is driven and popped when the unit completes.
module tb_branch_unit;
    logic        clk = 0, reset = 1, start = 0, bus_gnt = 0;
    logic [2:0]  IR_cond = 0;
    logic [7:0]  IR_offset = 0;
    logic [1:0]  PSW_in = 0;
    logic [15:0] PC_in = 0;
    logic        bus_req, PC_load, taken, busy, done;
    logic [15:0] PC_out;
    int checks = 0, failures = 0;

    typedef struct {logic tk; logic [15:0] pc;} exp_t;
    exp_t exp_q[$];
    exp_t e;

    branch_unit #(.DATA_W(16), .OFF_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .IR_cond(IR_cond),
        .IR_offset(IR_offset), .PSW_in(PSW_in), .PC_in(PC_in), .bus_gnt(bus_gnt),
        .bus_req(bus_req), .PC_out(PC_out), .PC_load(PC_load), .taken(taken),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic logic ref_taken(input logic [2:0] c, input logic [1:0] p);
        logic zz, nn;
        zz = p[0];
        nn = p[1];
        case (c)
            3'd0: return 1'b1;
            3'd1: return zz;
            3'd2: return !zz;
            3'd3: return nn;
            3'd4: return !nn;
            3'd5: return nn || zz;
            3'd6: return !nn && !zz;
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench one cycle after the start edge (EVAL); scrambles the
    // inputs afterwards so any late sampling shows up as a wrong result.
    task automatic do_start(input logic [2:0] c, input logic [7:0] o, input logic [1:0] p, input logic [15:0] pc);
        exp_t x;
        IR_cond = c; IR_offset = o; PSW_in = p; PC_in = pc; start = 1;
        x.tk = ref_taken(c, p);
        x.pc = pc + {{8{o[7]}}, o};
        exp_q.push_back(x);
        tick();
        start = 0; PSW_in = ~p; IR_cond = ~c; IR_offset = ~o; PC_in = ~pc;
    endtask

    task automatic test_reset;
        reset = 1;
        tick(); tick();
        reset = 0;
        checks++;
        if ({bus_req, PC_load, done, busy, taken} !== 5'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=00000", {bus_req, PC_load, done, busy, taken});
        end
        checks++;
        if (PC_out !== 16'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0000", PC_out); end
        // reset and start together: reset wins
        reset = 1; start = 1;
        tick();
        reset = 0; start = 0;
        tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_start_busy got=%b exp=0", busy); end
    endtask

    task automatic test_not_taken;
        do_start(3'b001, 8'h10, 2'b00, 16'h0100);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL nt_eval got=%b%b exp=10", busy, done); end
        tick();
        e = exp_q.pop_front();
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL nt_done got=%b exp=1", done); end
        checks++;
        if (taken !== e.tk) begin failures++; $display("FAIL nt_taken got=%b exp=%b", taken, e.tk); end
        checks++;
        if (bus_req !== 1'b0 || PC_load !== 1'b0) begin failures++; $display("FAIL nt_bus got=%b%b exp=00", bus_req, PC_load); end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL nt_idle got=%b%b exp=00", busy, done); end
    endtask

    task automatic test_taken_forward;
        bus_gnt = 1;
        do_start(3'b001, 8'h10, 2'b01, 16'h0100);
        tick();
        checks++;
        if (bus_req !== 1'b0) begin failures++; $display("FAIL fw_calc_req got=%b exp=0", bus_req); end
        tick();
        checks++;
        if (bus_req !== 1'b1) begin failures++; $display("FAIL fw_req got=%b exp=1", bus_req); end
        tick();
        e = exp_q.pop_front();
        checks++;
        if (PC_load !== 1'b1 || bus_req !== 1'b0) begin failures++; $display("FAIL fw_load got=%b%b exp=10", PC_load, bus_req); end
        checks++;
        if (PC_out !== e.pc) begin failures++; $display("FAIL fw_target got=%h exp=%h", PC_out, e.pc); end
        tick();
        checks++;
        if (done !== 1'b1 || PC_load !== 1'b0) begin failures++; $display("FAIL fw_done got=%b%b exp=10", done, PC_load); end
        checks++;
        if (taken !== e.tk) begin failures++; $display("FAIL fw_taken got=%b exp=%b", taken, e.tk); end
        tick();
    endtask

    task automatic test_taken_wrap;
        bus_gnt = 1;
        do_start(3'b000, 8'hFC, 2'b10, 16'h0002);
        for (int i = 0; i < 20 && PC_load !== 1'b1; i++) tick();
        e = exp_q.pop_front();
        checks++;
        if (PC_load !== 1'b1) begin failures++; $display("FAIL wrap_load_timeout got=%b exp=1", PC_load); end
        checks++;
        if (PC_out !== e.pc) begin failures++; $display("FAIL wrap_target got=%h exp=%h", PC_out, e.pc); end
        tick(); tick();
        // 0xFFFF + 1 wraps to zero
        do_start(3'b000, 8'h01, 2'b00, 16'hFFFF);
        for (int i = 0; i < 20 && PC_load !== 1'b1; i++) tick();
        e = exp_q.pop_front();
        checks++;
        if (PC_out !== e.pc || PC_load !== 1'b1) begin failures++; $display("FAIL wrap_up got=%h/%b exp=%h/1", PC_out, PC_load, e.pc); end
        tick(); tick();
    endtask

    task automatic test_held_grant;
        bus_gnt = 0;
        do_start(3'b110, 8'h20, 2'b00, 16'h0400);
        tick();
        PSW_in = 2'b01;
        tick();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (bus_req !== 1'b1) begin failures++; $display("FAIL hold_req%0d got=%b exp=1", i, bus_req); end
            start = (i == 2);
            if (i == 5) bus_gnt = 1;
            tick();
        end
        start = 0;
        bus_gnt = 0;
        e = exp_q.pop_front();
        checks++;
        if (PC_load !== 1'b1 || bus_req !== 1'b0) begin failures++; $display("FAIL hold_load got=%b%b exp=10", PC_load, bus_req); end
        checks++;
        if (PC_out !== e.pc) begin failures++; $display("FAIL hold_target got=%h exp=%h", PC_out, e.pc); end
        checks++;
        if (taken !== e.tk) begin failures++; $display("FAIL hold_taken got=%b exp=%b", taken, e.tk); end
        tick();
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL hold_done got=%b exp=1", done); end
        tick(); tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL hold_ignored_start got=%b exp=0", busy); end
    endtask

    task automatic test_cond_sweep;
        bus_gnt = 1;
        for (int c = 0; c < 8; c++) begin
            for (int p = 0; p < 4; p++) begin
                do_start(3'(c), 8'(c * 4 + p), 2'(p), 16'(16'h1000 + c * 16));
                tick();
                e = exp_q.pop_front();
                checks++;
                if (taken !== e.tk) begin failures++; $display("FAIL sweep_c%0d_p%0d got=%b exp=%b", c, p, taken, e.tk); end
                for (int i = 0; i < 10 && busy === 1'b1; i++) tick();
                checks++;
                if (busy !== 1'b0) begin failures++; $display("FAIL sweep_idle_c%0d_p%0d got=%b exp=0", c, p, busy); end
            end
        end
        bus_gnt = 0;
    endtask

    task automatic test_back_to_back;
        do_start(3'b011, 8'h00, 2'b00, 16'h0010);
        tick();
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL b2b_done1 got=%b exp=1", done); end
        void'(exp_q.pop_front());
        tick();
        do_start(3'b111, 8'h00, 2'b11, 16'h0020);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", busy); end
        tick();
        e = exp_q.pop_front();
        checks++;
        if (done !== 1'b1 || taken !== e.tk) begin failures++; $display("FAIL b2b_done2 got=%b%b exp=1%b", done, taken, e.tk); end
        tick();
    endtask

    task automatic test_reset_in_req;
        bus_gnt = 0;
        do_start(3'b000, 8'h05, 2'b00, 16'h1234);
        tick(); tick();
        e = exp_q.pop_front();
        checks++;
        if (bus_req !== 1'b1 || PC_out !== e.pc) begin failures++; $display("FAIL rreq_pre got=%b/%h exp=1/%h", bus_req, PC_out, e.pc); end
        reset = 1;
        tick();
        reset = 0;
        checks++;
        if ({bus_req, busy, taken, done} !== 4'b0) begin failures++; $display("FAIL rreq_ctrl got=%b exp=0000", {bus_req, busy, taken, done}); end
        checks++;
        if (PC_out !== 16'h0) begin failures++; $display("FAIL rreq_pc got=%h exp=0000", PC_out); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rreq_quiet%0d got=%b%b exp=00", i, done, busy); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_not_taken();
        test_taken_forward();
        test_taken_wrap();
        test_held_grant();
        test_cond_sweep();
        test_back_to_back();
        test_reset_in_req();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_unit.md
# branch_unit

Condition-code consumer for the FPG8 datapath. It reads the Z/N flags held in the processor status word, evaluates the branch condition encoded in the instruction register, and computes the branch target. For a taken branch it requests the bus, then drives a one-cycle PC load. It sits between the PSW, the instruction register and the program counter, and the control unit steps it with a start/done handshake.

## Interface
- DATA_W, 16, width of PC and target datapath
- OFF_W, 8, width of the signed branch offset field in IR
- clk  in  1  system clock, all state changes on rising edge
- reset  in  1  synchronous, active-high; clock clk
- start  in  1  control unit pulse: IR holds a branch, begin evaluation
- IR_cond  in  3  branch condition field
- IR_offset  in  OFF_W  two's-complement branch offset
- PSW_in  in  2  status flags: bit0 = Z, bit1 = N
- PC_in  in  DATA_W  current (already incremented) program counter
- bus_gnt  in  1  bus grant from arbiter
- bus_req  out  1  bus request, held until granted
- PC_out  out  DATA_W  branch target
- PC_load  out  1  one-cycle strobe: PC must load PC_out
- taken  out  1  registered result of the last evaluation
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, EVAL, CALC, REQ, LOAD, DONE.
- IDLE: start=1 is accepted. IR_cond, IR_offset, PSW_in and PC_in are snapshotted into internal registers on that edge. Next state is EVAL. start in any other state is ignored; there is no queueing.
- EVAL: the condition is computed from the snapshotted Z and N and registered into taken. Next state is CALC if taken, otherwise DONE.
- Condition encoding:
  - 000 always
  - 001 Z
  - 010 !Z
  - 011 N
  - 100 !N
  - 101 N|Z
  - 110 !N&!Z
  - 111 never
- CALC: target = PC_snap + sign_extend(offset_snap) mod 2^DATA_W, registered into PC_out. Next state is REQ.
- REQ: bus_req=1. If bus_gnt is sampled high, next state is LOAD; otherwise the FSM stays in REQ indefinitely. There is no timeout.
- LOAD: PC_load=1, PC_out=target, bus_req=0. Next state is DONE.
- DONE: done=1. Next state is IDLE.
- bus_gnt is ignored outside REQ.
- PSW_in changes after the start edge have no effect on the current branch.
- PC_out holds its value until the next CALC.
- taken holds its value until the next EVAL.
- Arithmetic: the offset is sign-extended from bit OFF_W-1. Overflow and underflow wrap silently (0xFFFF+1 → 0x0000, 0x0000-1 → 0xFFFF).

## Timing
- Reset values: state=IDLE, bus_req=0, PC_load=0, done=0, busy=0, taken=0, PC_out=0, all snapshots 0.
- Reset mid-operation: return to IDLE on the next edge. bus_req and PC_load drop that same edge; no done pulse is issued.
- Cycle numbering: start is sampled high at edge k.
  - Cycle k+1: EVAL.
  - Cycle k+2: DONE (not taken) or CALC (taken).
- Not-taken latency: done is high in cycle k+2. The unit is back in IDLE, and can accept start again, at cycle k+3.
- Taken, REQ entry: REQ is entered at k+3, and bus_req is high from cycle k+3.
- Taken, grant to completion: grant is sampled high at the end of REQ cycle j. LOAD (PC_load=1) is cycle j+1 and DONE is cycle j+2.
- Taken, minimum latency: with a grant in the first REQ cycle, PC_load is at k+4 and done is at k+5.
- PC_load and done are exactly one cycle wide and never overlap.
- bus_req never overlaps PC_load.
- Simultaneous reset and start: reset wins, and the unit stays in IDLE.

## Test plan
- Not taken: PSW_in=2'b00, IR_cond=001, start. Required: taken=0, done at k+2, no bus_req, no PC_load.
- Taken forward: PSW_in=2'b01, IR_cond=001, PC_in=0x0100, IR_offset=0x10, bus_gnt tied 1. Required: bus_req at k+3, PC_load at k+4 with PC_out=0x0110, done at k+5.
- Taken backward with wrap: IR_cond=000, PC_in=0x0002, IR_offset=0xFC. Required: PC_out=0xFFFE.
- Held grant: IR_cond=110, PSW_in=2'b00, bus_gnt low for 5 REQ cycles then high. Required: bus_req high for all 6 REQ cycles, PC_load on the following cycle, PSW_in toggled to 2'b01 during REQ has no effect.
- Condition sweep: all 8 IR_cond values × 4 PSW values. Required: taken matches the encoding table; 111 is never taken, 000 is always taken.
- Reset in REQ: assert reset while bus_req=1. Required: next cycle bus_req=0, busy=0, taken=0, PC_out=0, no done pulse; start is ignored while busy in every state.
